// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, tracks in-flight requests,
// buffers returned words in a prefetch FIFO, and discards stale responses after redirects.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_vld,
  input  logic [31:0] i_redirect_pc,
  output logic        o_insn_vld,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc,
  input  logic        i_insn_rdy,
  output logic        o_misaligned,
  output logic [31:0] o_pc_debug
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 2;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [0:0] {RUN, MISALIGN} state_t;

  state_t state, state_nxt;

  logic [31:0]   f_pc;
  logic [31:0]   fifo_insn [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   tag_pc    [DEPTH];
  logic [AW-1:0] fifo_rd, fifo_wr;
  logic [AW-1:0] tag_rd, tag_wr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] live;
  logic          handshake;
  logic          rsp_live;
  logic          push;
  logic          pop;

  // Stale requests are the ones drop_cnt will swallow; the rest own a tag entry.
  assign live      = inflight - drop_cnt;
  assign handshake = o_imem_req & i_imem_ready;
  assign rsp_live  = i_imem_rvalid & (drop_cnt == '0);
  assign push      = rsp_live & ~i_redirect_vld;
  assign pop       = o_insn_vld & i_insn_rdy & ~i_redirect_vld;

  assign o_imem_req  = ~i_rst & (state == RUN) & ~i_redirect_vld &
                       ((SW'(fifo_count) + SW'(live)) < SW'(DEPTH));
  assign o_imem_addr = f_pc;

  assign o_insn_vld   = ~i_rst & (fifo_count != '0);
  assign o_insn       = fifo_insn[fifo_rd];
  assign o_pc         = fifo_pc[fifo_rd];
  assign o_misaligned = (state == MISALIGN);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  // Any redirect decides the mode purely from target alignment.
  always_comb begin
    state_nxt = state;
    if (i_redirect_vld) begin
      state_nxt = (i_redirect_pc[1:0] != 2'b00) ? MISALIGN : RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      f_pc       <= RESET_PC;
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
      tag_rd     <= '0;
      tag_wr     <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      o_pc_debug <= '0;
    end else if (i_redirect_vld) begin
      // Everything still outstanding becomes stale; a same-cycle response is already gone.
      f_pc       <= i_redirect_pc;
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
      tag_rd     <= '0;
      tag_wr     <= '0;
      inflight   <= inflight - CW'(i_imem_rvalid);
      drop_cnt   <= inflight - CW'(i_imem_rvalid);
    end else begin
      if (handshake) f_pc <= f_pc + 32'd4;
      if (push)      fifo_wr <= fifo_wr + AW'(1);
      if (pop)       fifo_rd <= fifo_rd + AW'(1);
      if (pop)       o_pc_debug <= o_pc;
      if (handshake) tag_wr <= tag_wr + AW'(1);
      if (rsp_live)  tag_rd <= tag_rd + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      inflight   <= inflight + CW'(handshake) - CW'(i_imem_rvalid);
      if (i_imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Payload storage needs no reset; validity lives in the pointers and counts.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_insn[fifo_wr] <= i_imem_rdata;
      fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
    end
    if (handshake) tag_pc[tag_wr] <= f_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fixed-latency memory model, hand-computed PC/insn expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        insn_vld;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        insn_rdy;
  logic        misaligned;
  logic [31:0] pc_debug;

  int errors = 0;
  int checks = 0;
  int hs_cnt;

  logic [1:0]  lat_idx;
  logic [2:0]  p_vld;
  logic [31:0] p_addr [3];

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_ready   (imem_ready),
    .i_imem_rvalid  (imem_rvalid),
    .i_imem_rdata   (imem_rdata),
    .i_redirect_vld (redirect_vld),
    .i_redirect_pc  (redirect_pc),
    .o_insn_vld     (insn_vld),
    .o_insn         (insn),
    .o_pc           (pc),
    .i_insn_rdy     (insn_rdy),
    .o_misaligned   (misaligned),
    .o_pc_debug     (pc_debug)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A5A_A5A5;
  endfunction

  // In-order memory with latency lat_idx+1 cycles; emptied by reset.
  always @(posedge clk) begin
    if (rst) begin
      p_vld <= 3'b000;
    end else begin
      p_vld     <= {p_vld[1:0], imem_req & imem_ready};
      p_addr[0] <= imem_addr;
      p_addr[1] <= p_addr[0];
      p_addr[2] <= p_addr[1];
    end
  end

  assign imem_rvalid = p_vld[lat_idx];
  assign imem_rdata  = imem_rvalid ? mem_word(p_addr[lat_idx]) : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      smp();
    end
  endtask

  // Two reset cycles, then release; returns at the sample point of cycle 0.
  task automatic do_reset(input logic [1:0] lat);
    cyc();
    rst = 1'b1;
    redirect_vld = 1'b0;
    lat_idx = lat;
    smp();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_vld", 32'(insn_vld), 32'd0);
    cyc();
    smp();
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_pc_debug", pc_debug, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    cyc();
    rst = 1'b0;
    smp();
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    while (!(insn_vld && insn_rdy) && n < 30) begin
      cyc();
      smp();
      n++;
    end
    if (insn_vld && insn_rdy) begin
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_insn"}, insn, mem_word(exp_pc));
    end else begin
      check({tag, "_timeout"}, 32'(insn_vld), 32'd1);
    end
    cyc();
    smp();
  endtask

  task automatic redirect(input logic [31:0] target);
    cyc();
    redirect_vld = 1'b1;
    redirect_pc  = target;
    smp();
    check("redir_req_off", 32'(imem_req), 32'd0);
    cyc();
    redirect_vld = 1'b0;
    smp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b1; redirect_vld = 1'b0; redirect_pc = 32'h0;
    insn_rdy = 1'b1; lat_idx = 2'd0;

    // Streaming with a 1-cycle memory
    do_reset(2'd0);
    check("s_req0", 32'(imem_req), 32'd1);
    check("s_addr0", imem_addr, 32'h0);
    cyc(); smp();
    check("s_vld1", 32'(insn_vld), 32'd0);
    check("s_addr1", imem_addr, 32'h4);
    for (int k = 0; k < 8; k++) begin
      cyc(); smp();
      check("s_vld", 32'(insn_vld), 32'd1);
      check("s_pc", pc, 32'(4 * k));
      check("s_insn", insn, mem_word(32'(4 * k)));
    end
    cyc(); smp();
    check("s_pc_debug", pc_debug, 32'h1C);

    // Backpressure: FIFO plus in-flight capped at 4
    insn_rdy = 1'b0;
    do_reset(2'd0);
    hs_cnt = (imem_req && imem_ready) ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      cyc(); smp();
      if (imem_req && imem_ready) hs_cnt++;
    end
    check("bp_handshakes", 32'(hs_cnt), 32'd4);
    check("bp_req_off", 32'(imem_req), 32'd0);
    check("bp_head", pc, 32'h0);
    cyc();
    insn_rdy = 1'b1;
    smp();
    wait_pop("bp0", 32'h0);
    wait_pop("bp1", 32'h4);
    wait_pop("bp2", 32'h8);
    wait_pop("bp3", 32'hC);
    wait_pop("bp4", 32'h10);

    // Redirect with three outstanding requests on a 3-cycle memory
    do_reset(2'd2);
    idle(2);
    redirect(32'h100);
    check("rd_req", 32'(imem_req), 32'd1);
    check("rd_addr", imem_addr, 32'h100);
    check("rd_vld_c4", 32'(insn_vld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      check("rd_no_stale", 32'(insn_vld), 32'd0);
    end
    wait_pop("rd0", 32'h100);
    wait_pop("rd1", 32'h104);
    wait_pop("rd2", 32'h108);

    // Redirect colliding with a response and a pop
    do_reset(2'd0);
    idle(4);
    cyc();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h300;
    smp();
    check("col_vld", 32'(insn_vld), 32'd1);
    check("col_pc", pc, 32'hC);
    check("col_rvalid", 32'(imem_rvalid), 32'd1);
    cyc();
    redirect_vld = 1'b0;
    smp();
    check("col_empty", 32'(insn_vld), 32'd0);
    check("col_addr", imem_addr, 32'h300);
    check("col_pc_debug", pc_debug, 32'h8);
    cyc(); smp();
    check("col_empty2", 32'(insn_vld), 32'd0);
    wait_pop("col0", 32'h300);
    wait_pop("col1", 32'h304);

    // Misaligned redirect stalls fetch until an aligned redirect
    redirect(32'h102);
    check("mis_flag", 32'(misaligned), 32'd1);
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_vld", 32'(insn_vld), 32'd0);
    idle(3);
    check("mis_hold_req", 32'(imem_req), 32'd0);
    check("mis_hold_vld", 32'(insn_vld), 32'd0);
    redirect(32'h103);
    check("mis_again", 32'(misaligned), 32'd1);
    check("mis_again_req", 32'(imem_req), 32'd0);
    redirect(32'h200);
    check("mis_clear", 32'(misaligned), 32'd0);
    check("mis_addr", imem_addr, 32'h200);
    wait_pop("mis0", 32'h200);
    wait_pop("mis1", 32'h204);

    // Address wrap at the top of the space
    redirect(32'hFFFF_FFF8);
    wait_pop("wr0", 32'hFFFF_FFF8);
    wait_pop("wr1", 32'hFFFF_FFFC);
    wait_pop("wr2", 32'h0000_0000);
    wait_pop("wr3", 32'h0000_0004);

    // Reset mid-operation with a full FIFO
    insn_rdy = 1'b0;
    idle(6);
    check("full_vld", 32'(insn_vld), 32'd1);
    insn_rdy = 1'b1;
    do_reset(2'd0);
    check("post_rst_addr", imem_addr, 32'h0);
    wait_pop("prst0", 32'h0);
    wait_pop("prst1", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
